// File: rtl/spi_target_if.sv
// SPI pins plus RX/TX holding-register handshakes for spi_target.
// The slave modport is the target's view; master is the controller/consumer side.
interface spi_target_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  io_spi_sclk;
  logic                  io_spi_ss;
  logic                  io_spi_mosi;
  logic                  io_spi_miso;
  logic                  io_spi_miso_oe;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  rx_overrun;
  logic                  tx_underrun;

  modport slave (
    input  io_spi_sclk, io_spi_ss, io_spi_mosi, rx_ready, tx_data, tx_valid,
    output io_spi_miso, io_spi_miso_oe, rx_data, rx_valid, tx_ready, busy,
           rx_overrun, tx_underrun
  );

  modport master (
    output io_spi_sclk, io_spi_ss, io_spi_mosi, rx_ready, tx_data, tx_valid,
    input  io_spi_miso, io_spi_miso_oe, rx_data, rx_valid, tx_ready, busy,
           rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, with all pins oversampled in the io_clock domain.
// One-entry RX and TX holding registers face on-chip logic via valid/ready.
module spi_target #(
  parameter int unsigned                DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]      DEFAULT_TX = 8'hFF
) (
  input  logic        io_clock,
  input  logic        io_reset_n,
  spi_target_if.slave bus
);
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e                state;
  logic [2:0]            sclk_q;
  logic [2:0]            ss_q;
  logic [1:0]            mosi_q;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_hold;
  logic                  tx_full;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  miso;
  logic                  miso_oe;
  logic                  busy;
  logic                  rx_overrun;
  logic                  tx_underrun;
  logic                  load_pending;

  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  ss_fall;
  logic                  ss_rise;
  logic                  last_bit;
  logic                  tx_write;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] load_word;

  // Stage [1] is the synchronised value, stage [2] the history used for edges.
  // MOSI is only sampled, never edge-detected, so it needs no history flop.
  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    sclk_fall = ~sclk_q[1] & sclk_q[2];
    ss_fall   = ~ss_q[1] & ss_q[2];
    ss_rise   = ss_q[1] & ~ss_q[2];
    last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
    tx_write  = bus.tx_valid & ~tx_full;
    rx_word   = {rx_shift, mosi_q[1]};
    load_word = tx_full ? tx_hold : DEFAULT_TX;
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state        <= IDLE;
      sclk_q       <= '0;
      ss_q         <= '1;
      mosi_q       <= '0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_full      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      busy         <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_underrun  <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[1:0], bus.io_spi_sclk};
      ss_q        <= {ss_q[1:0], bus.io_spi_ss};
      mosi_q      <= {mosi_q[0], bus.io_spi_mosi};
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      if (rx_valid && bus.rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A write never coincides with a load that empties the register
      // (write needs it empty, the clear needs it full), so a same-cycle
      // write survives for the next frame while the load sees the old state.
      if (tx_write) begin
        tx_hold <= bus.tx_data;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state        <= ACTIVE;
            busy         <= 1'b1;
            miso_oe      <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            load_pending <= 1'b0;
            tx_shift     <= load_word;
            miso         <= load_word[DATA_WIDTH-1];
            if (tx_full) begin
              tx_full <= 1'b0;
            end else begin
              tx_underrun <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state        <= IDLE;
            busy         <= 1'b0;
            miso_oe      <= 1'b0;
            miso         <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            load_pending <= 1'b0;
          end else if (sclk_rise) begin
            if (last_bit) begin
              bit_cnt  <= '0;
              rx_shift <= '0;
              if (rx_valid && !bus.rx_ready) begin
                rx_overrun <= 1'b1;
              end else begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
              end
              // New word's MSB waits for the next SCLK fall.
              tx_shift     <= load_word;
              load_pending <= 1'b1;
              if (tx_full) begin
                tx_full <= 1'b0;
              end else begin
                tx_underrun <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              rx_shift <= rx_word[DATA_WIDTH-2:0];
            end
          end else if (sclk_fall) begin
            if (load_pending) begin
              miso         <= tx_shift[DATA_WIDTH-1];
              load_pending <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              miso     <= tx_shift[DATA_WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_spi_miso    = miso;
  assign bus.io_spi_miso_oe = miso_oe;
  assign bus.rx_data        = rx_data;
  assign bus.rx_valid       = rx_valid;
  assign bus.tx_ready       = ~tx_full;
  assign bus.busy           = busy;
  assign bus.rx_overrun     = rx_overrun;
  assign bus.tx_underrun    = tx_underrun;
endmodule
